// File: rtl/fdtd_step_sched_if.sv
// Phase handshake between the time-step scheduler (master) and the calculation
// controller / write-back path (slave): start flags out, completion pulses back.
interface fdtd_step_sched_if;
  logic calc_Hy_flg_o;
  logic calc_Ez_flg_o;
  logic calc_src_flg_o;
  logic hy_done_i;
  logic ez_done_i;
  logic src_done_i;

  modport master (
    output calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o,
    input  hy_done_i, ez_done_i, src_done_i
  );

  modport slave (
    input  calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o,
    output hy_done_i, ez_done_i, src_done_i
  );
endinterface

// File: rtl/fdtd_step_sched.sv
// FDTD time-step scheduler: runs Hy, Ez and optional source phases per step,
// with a per-phase watchdog and an abort honoured at the next step boundary.
module fdtd_step_sched #(
  parameter int STEP_WIDTH = 16,
  parameter int TMO_WIDTH  = 16,
  parameter int TMO_CYC    = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [STEP_WIDTH-1:0] step_num_i,
  input  logic                  src_en_i,
  input  logic                  abort_i,
  fdtd_step_sched_if.master     calc_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic                  err_o,
  output logic [1:0]            err_phase_o,
  output logic [STEP_WIDTH-1:0] step_cnt_o
);

  typedef enum logic [3:0] {
    IDLE, ISSUE_HY, WAIT_HY, ISSUE_EZ, WAIT_EZ, ISSUE_SRC, WAIT_SRC, STEP_END, ERR
  } state_e;

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYC - 1);
  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_HY   = 2'd1;
  localparam logic [1:0] PH_EZ   = 2'd2;
  localparam logic [1:0] PH_SRC  = 2'd3;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_num_q, step_num_d;
  logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
  logic                  src_en_q, src_en_d;
  logic                  abort_q, abort_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  err_q, err_d;
  logic [1:0]            err_phase_q, err_phase_d;

  logic                  busy;
  logic [STEP_WIDTH-1:0] cnt_inc;
  logic                  phase_done;
  state_e                phase_next;
  logic [1:0]            phase_id;

  assign busy    = (state_q != IDLE) && (state_q != ERR);
  assign cnt_inc = step_cnt_q + STEP_WIDTH'(1);

  // Per-WAIT-state view: which completion pulse matters, where it leads, and
  // which phase code to report if the watchdog fires instead.
  always_comb begin
    phase_done = 1'b0;
    phase_next = IDLE;
    phase_id   = PH_NONE;
    case (state_q)
      WAIT_HY: begin
        phase_done = calc_if.hy_done_i;
        phase_next = ISSUE_EZ;
        phase_id   = PH_HY;
      end
      WAIT_EZ: begin
        phase_done = calc_if.ez_done_i;
        phase_next = src_en_q ? ISSUE_SRC : STEP_END;
        phase_id   = PH_EZ;
      end
      WAIT_SRC: begin
        phase_done = calc_if.src_done_i;
        phase_next = STEP_END;
        phase_id   = PH_SRC;
      end
      default: ;
    endcase
  end

  // NOTE: every next-state signal takes its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    step_num_d  = step_num_q;
    step_cnt_d  = step_cnt_q;
    tmo_d       = tmo_q;
    src_en_d    = src_en_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    err_d       = err_q;
    err_phase_d = err_phase_q;

    case (state_q)
      IDLE, ERR: begin
        if (start_i) begin
          step_num_d  = step_num_i;
          src_en_d    = src_en_i;
          step_cnt_d  = '0;
          abort_d     = 1'b0;
          aborted_d   = 1'b0;
          err_d       = 1'b0;
          err_phase_d = PH_NONE;
          if (step_num_i == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE_HY;
          end
        end
      end
      ISSUE_HY:  begin state_d = WAIT_HY;  tmo_d = '0; end
      ISSUE_EZ:  begin state_d = WAIT_EZ;  tmo_d = '0; end
      ISSUE_SRC: begin state_d = WAIT_SRC; tmo_d = '0; end
      WAIT_HY, WAIT_EZ, WAIT_SRC: begin
        // A completion arriving on the final allowed cycle still beats the watchdog.
        if (phase_done) begin
          state_d = phase_next;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ERR;
          err_d       = 1'b1;
          err_phase_d = phase_id;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      STEP_END: begin
        step_cnt_d = cnt_inc;
        if ((cnt_inc == step_num_q) || abort_q) begin
          done_d    = 1'b1;
          aborted_d = abort_q && (cnt_inc < step_num_q);
          state_d   = IDLE;
        end else begin
          state_d = ISSUE_HY;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy && abort_i) begin
      abort_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      step_num_q  <= '0;
      step_cnt_q  <= '0;
      tmo_q       <= '0;
      src_en_q    <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      err_phase_q <= PH_NONE;
    end else begin
      state_q     <= state_d;
      step_num_q  <= step_num_d;
      step_cnt_q  <= step_cnt_d;
      tmo_q       <= tmo_d;
      src_en_q    <= src_en_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
      err_phase_q <= err_phase_d;
    end
  end

  assign calc_if.calc_Hy_flg_o  = (state_q == ISSUE_HY);
  assign calc_if.calc_Ez_flg_o  = (state_q == ISSUE_EZ);
  assign calc_if.calc_src_flg_o = (state_q == ISSUE_SRC);
  assign busy_o      = busy;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;
  assign err_phase_o = err_phase_q;
  assign step_cnt_o  = step_cnt_q;

endmodule

// File: tb/tb_fdtd_step_sched.sv
// Randomised bench for fdtd_step_sched: each run is predicted as a per-cycle
// trace from phase latencies, then compared cycle by cycle against the DUT.
module tb_fdtd_step_sched;
  localparam int SW   = 16;
  localparam int TW   = 16;
  localparam int TMO  = 20;
  localparam int MAXC = 1024;

  localparam logic [4:0] V_HY   = 5'b10000;
  localparam logic [4:0] V_EZ   = 5'b01000;
  localparam logic [4:0] V_SRC  = 5'b00100;
  localparam logic [4:0] V_DONE = 5'b00010;
  localparam logic [4:0] V_BUSY = 5'b00001;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start_i;
  logic [SW-1:0] step_num_i;
  logic          src_en_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;
  logic          err_o;
  logic [1:0]    err_phase_o;
  logic [SW-1:0] step_cnt_o;

  fdtd_step_sched_if cif();

  fdtd_step_sched #(.STEP_WIDTH(SW), .TMO_WIDTH(TW), .TMO_CYC(TMO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start_i     (start_i),
    .step_num_i  (step_num_i),
    .src_en_i    (src_en_i),
    .abort_i     (abort_i),
    .calc_if     (cif),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .err_o       (err_o),
    .err_phase_o (err_phase_o),
    .step_cnt_o  (step_cnt_o)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] obs_vec();
    return {cif.calc_Hy_flg_o, cif.calc_Ez_flg_o, cif.calc_src_flg_o, done_o, busy_o};
  endfunction

  function automatic logic [31:0] all_out();
    return {7'd0, obs_vec(), aborted_o, err_o, err_phase_o, step_cnt_o};
  endfunction

  // Completion latency of the k-th phase of a run, counted in cycles after its flag.
  int lat [64];

  logic [4:0] exp_vec [MAXC];
  int         exp_cnt;
  bit         exp_abt;
  bit         exp_err;
  int         exp_ph;

  task automatic set_lat_all(input int v);
    for (int i = 0; i < 64; i++) lat[i] = v;
  endtask

  task automatic set_lat_rand();
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      lat[i] = TMO;
      else if (r == 1) lat[i] = TMO + 1 + $urandom_range(0, 3);
      else             lat[i] = $urandom_range(1, 12);
    end
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int c = from; c <= to; c++) exp_vec[c] = exp_vec[c] | V_BUSY;
  endtask

  // Timeline of one run: start sampled at edge 0, so the Hy flag is seen at
  // index 0; a phase with latency L occupies L wait cycles and the following
  // event appears L+1 cycles after its flag.
  task automatic model_run(input int n, input bit src, input int abort_step, output int end_e);
    int t;
    int k;
    int nph;
    logic [4:0] fl;
    for (int c = 0; c < MAXC; c++) exp_vec[c] = '0;
    exp_cnt = 0;
    exp_abt = 1'b0;
    exp_err = 1'b0;
    exp_ph  = 0;
    if (n == 0) begin
      exp_vec[0] = V_DONE;
      end_e = 0;
      return;
    end
    t   = 0;
    k   = 0;
    nph = src ? 3 : 2;
    for (int s = 0; s < n; s++) begin
      for (int p = 1; p <= nph; p++) begin
        fl = (p == 1) ? V_HY : (p == 2) ? V_EZ : V_SRC;
        exp_vec[t] = exp_vec[t] | fl;
        if (lat[k] > TMO) begin
          mark_busy(t, t + TMO);
          exp_err = 1'b1;
          exp_ph  = p;
          end_e   = t + TMO + 1;
          return;
        end
        mark_busy(t, t + lat[k]);
        t = t + lat[k] + 1;
        k++;
      end
      mark_busy(t, t);
      exp_cnt = s + 1;
      if (exp_cnt == n || s == abort_step) begin
        exp_abt = (s == abort_step) && (exp_cnt < n);
        exp_vec[t + 1] = exp_vec[t + 1] | V_DONE;
        end_e = t + 1;
        return;
      end
      t = t + 1;
    end
    end_e = t;
  endtask

  task automatic clear_inputs();
    start_i        = 1'b0;
    abort_i        = 1'b0;
    cif.hy_done_i  = 1'b0;
    cif.ez_done_i  = 1'b0;
    cif.src_done_i = 1'b0;
  endtask

  // Responder reacts to observed flags with the chosen latencies and sprinkles
  // completion pulses of the wrong phase while a phase is outstanding.
  task automatic do_run(input string name, input int n, input bit src,
                        input int abort_step, input bit abort_with_start);
    int end_e;
    int pend;
    int due;
    int k;
    int hy_seen;
    int abort_at;
    logic [4:0] v;
    model_run(n, src, abort_step, end_e);
    start_i    = 1'b1;
    step_num_i = SW'(n);
    src_en_i   = src;
    abort_i    = abort_with_start;
    @(posedge CLK); #1;
    clear_inputs();
    step_num_i = SW'($urandom);
    src_en_i   = 1'($urandom);
    check({name, "_start_status"}, {28'd0, aborted_o, err_o, err_phase_o}, 32'd0);
    pend = 0; due = -1; k = 0; hy_seen = 0; abort_at = -1;
    for (int e = 0; e <= end_e + 2; e++) begin
      if (e > 0) begin
        @(posedge CLK); #1;
      end
      v = obs_vec();
      check($sformatf("%s_cyc%0d", name, e), 32'(v), 32'(exp_vec[e]));
      clear_inputs();
      if (v[4]) begin
        pend = 1; due = e + lat[k]; k++;
        if (hy_seen == abort_step) abort_at = e + 1;
        hy_seen++;
      end else if (v[3]) begin
        pend = 2; due = e + lat[k]; k++;
      end else if (v[2]) begin
        pend = 3; due = e + lat[k]; k++;
      end
      if (e == abort_at) abort_i = 1'b1;
      if (pend != 0) begin
        cif.hy_done_i  = (pend != 1) && ($urandom_range(0, 3) == 0);
        cif.ez_done_i  = (pend != 2) && ($urandom_range(0, 3) == 0);
        cif.src_done_i = (pend != 3) && ($urandom_range(0, 3) == 0);
      end
      if (pend != 0 && due == e) begin
        case (pend)
          1:       cif.hy_done_i  = 1'b1;
          2:       cif.ez_done_i  = 1'b1;
          default: cif.src_done_i = 1'b1;
        endcase
        pend = 0;
      end
    end
    clear_inputs();
    check({name, "_step_cnt"}, 32'(step_cnt_o), 32'(exp_cnt));
    check({name, "_aborted"},  32'(aborted_o),  32'(exp_abt));
    check({name, "_err"},      32'(err_o),      32'(exp_err));
    check({name, "_err_phase"}, 32'(err_phase_o), 32'(exp_ph));
  endtask

  // Reset asserted for three cycles while the Ez phase is outstanding.
  task automatic reset_mid_run();
    start_i    = 1'b1;
    step_num_i = SW'(3);
    src_en_i   = 1'b0;
    @(posedge CLK); #1;
    clear_inputs();
    check("rst_hy_flag", 32'(obs_vec()), 32'(V_HY | V_BUSY));
    @(posedge CLK); #1;
    cif.hy_done_i = 1'b1;
    @(posedge CLK); #1;
    cif.hy_done_i = 1'b0;
    check("rst_ez_flag", 32'(obs_vec()), 32'(V_EZ | V_BUSY));
    @(posedge CLK); #1;
    check("rst_wait_ez", 32'(obs_vec()), 32'(V_BUSY));
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("rst_hold%0d", i), all_out(), 32'd0);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check($sformatf("rst_after%0d", i), all_out(), 32'd0);
    end
  endtask

  initial begin
    RST        = 1'b1;
    step_num_i = '0;
    src_en_i   = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("por%0d", i), all_out(), 32'd0);
    end
    RST = 1'b0;
    @(posedge CLK); #1;

    set_lat_all(10);
    do_run("three_steps", 3, 1'b0, -1, 1'b0);
    do_run("two_src", 2, 1'b1, -1, 1'b0);
    do_run("abort_s2", 5, 1'b0, 1, 1'b0);
    do_run("abort_last", 2, 1'b1, 1, 1'b0);
    lat[1] = TMO + 5;
    do_run("tmo_ez", 3, 1'b0, -1, 1'b0);
    set_lat_all(3);
    do_run("after_err", 1, 1'b0, -1, 1'b1);
    do_run("zero_steps", 0, 1'b1, -1, 1'b0);
    set_lat_all(TMO);
    do_run("exact_tmo", 1, 1'b1, -1, 1'b0);
    set_lat_all(TMO + 1);
    do_run("tmo_hy", 2, 1'b1, -1, 1'b0);
    set_lat_all(4);
    lat[2] = TMO + 2;
    do_run("tmo_src", 2, 1'b1, -1, 1'b0);
    set_lat_all(1);
    do_run("min_step", 3, 1'b1, -1, 1'b0);
    reset_mid_run();
    do_run("post_rst", 2, 1'b0, -1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      int n;
      int ab;
      n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      set_lat_rand();
      do_run($sformatf("rnd%0d", r), n, 1'($urandom), ab, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
